// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
//   arb_state_t : arbiter FSM states
//   mem_txn_t   : one memory transaction as held in the mem_* registers
package mem_port_arbiter_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                    we;
    logic [PKG_ADDR_W-1:0]   addr;
    logic [PKG_DATA_W-1:0]   wdata;
    logic [PKG_DATA_W/8-1:0] be;
  } mem_txn_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals around the port arbiter.
//   if_*    : instruction fetch request/response
//   d_*     : load/store request/response
//   mem_*   : unified memory port
//   bus_err : timeout indication, stall_*_req : per-requester stall requests
// Modports: master = arbiter view, slave = requesters + memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_valid;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;

  logic bus_err;
  logic stall_if_req;
  logic stall_d_req;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_err, stall_if_req, stall_d_req
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_err, stall_if_req, stall_d_req
  );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Transaction timeout counter for the memory port arbiter.
//   clk, nreset : clock, synchronous active-low reset
//   start_i     : transaction granted; zero the count and begin counting
//   clear_i     : transaction finished; stop counting
//   expire_o    : count reached TIMEOUT-1 while armed
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic nreset,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);
  logic [7:0] tmo_cnt_q;
  logic       armed_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      tmo_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else if (start_i) begin
      tmo_cnt_q <= '0;
      armed_q   <= 1'b1;
    end else if (clear_i) begin
      tmo_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else if (armed_q) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  assign expire_o = armed_q && (tmo_cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and
// load/store. Data has priority; a starvation counter forces a fetch grant
// after MAX_STARVE consecutive data grants while fetch waits. One
// transaction in flight, variable-latency ack, watchdog abort.
//   clk, nreset : clock, synchronous active-low reset
//   bus         : requester + memory signals (master modport)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = PKG_ADDR_W,
  parameter int DATA_W     = PKG_DATA_W,
  parameter int MAX_STARVE = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic clk,
  input  logic nreset,
  mem_port_arbiter_if.master bus
);
  arb_state_t state_q;
  mem_txn_t   txn_q;
  logic       mem_req_q;
  logic [3:0] starve_cnt_q;

  logic grant_if, grant_d, busy, expire, done, abort;

  always_comb begin
    // Fetch wins when alone or when data has starved it long enough.
    grant_if = bus.if_req && (!bus.d_req || (starve_cnt_q == 4'(MAX_STARVE)));
    grant_d  = bus.d_req && !grant_if;
    busy     = (state_q != IDLE);
    done     = busy && (bus.mem_ack || expire);
    // A same-cycle ack beats the timeout.
    abort    = busy && expire && !bus.mem_ack;
  end

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .nreset   (nreset),
    .start_i  ((state_q == IDLE) && (grant_if || grant_d)),
    .clear_i  (done),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      txn_q        <= '0;
      mem_req_q    <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_if) begin
            state_q      <= BUSY_IF;
            mem_req_q    <= 1'b1;
            txn_q.we     <= 1'b0;
            txn_q.addr   <= bus.if_addr;
            txn_q.wdata  <= '0;
            txn_q.be     <= '1;
            starve_cnt_q <= '0;
          end else if (grant_d) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            txn_q.we    <= bus.d_we;
            txn_q.addr  <= bus.d_addr;
            txn_q.wdata <= bus.d_wdata;
            txn_q.be    <= bus.d_be;
            if (bus.if_req && (starve_cnt_q < 4'(MAX_STARVE)))
              starve_cnt_q <= starve_cnt_q + 4'd1;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = txn_q.we;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_wdata = txn_q.wdata;
  assign bus.mem_be    = txn_q.be;

  // Completion is combinational on the ack (or expiry) cycle.
  assign bus.if_valid = (state_q == BUSY_IF) && done;
  assign bus.d_valid  = (state_q == BUSY_D) && done;
  assign bus.bus_err  = abort;
  assign bus.if_rdata = abort ? '0 : bus.mem_rdata;
  assign bus.d_rdata  = abort ? '0 : bus.mem_rdata;

  assign bus.stall_if_req = bus.if_req && !bus.if_valid;
  assign bus.stall_d_req  = bus.d_req && !bus.d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk;
  logic nreset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Starvation sequence: 1 = data grant expected, and starve count after it.
  int exp_d [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  int exp_sc[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STARVE(3), .TIMEOUT(8)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset = 1'b0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    // Reset state
    step(); step();
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    chk("rst_valids", {29'd0, bus.if_valid, bus.d_valid, bus.bus_err}, 0);
    nreset = 1'b1;

    // Fetch only, ack two cycles after mem_req rises
    step();
    bus.if_req = 1; bus.if_addr = 32'h100;
    #1 chk("f_stall_idle", 32'(bus.stall_if_req), 1);
    chk("f_req_idle", 32'(bus.mem_req), 0);
    step();
    chk("f_req", 32'(bus.mem_req), 1);
    chk("f_addr", bus.mem_addr, 32'h100);
    chk("f_be", 32'(bus.mem_be), 32'hF);
    chk("f_we", 32'(bus.mem_we), 0);
    step();
    #1 chk("f_novalid", 32'(bus.if_valid), 0);
    chk("f_stall_wait", 32'(bus.stall_if_req), 1);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
    #1 chk("f_valid", 32'(bus.if_valid), 1);
    chk("f_rdata", bus.if_rdata, 32'h00500093);
    chk("f_stall_done", 32'(bus.stall_if_req), 0);
    chk("f_err", 32'(bus.bus_err), 0);
    bus.if_req = 0;
    step();
    bus.mem_ack = 0;
    #1 chk("f_req_drop", 32'(bus.mem_req), 0);
    chk("f_valid_once", 32'(bus.if_valid), 0);

    // Both requesters held, 1-cycle memory: D,D,D,IF,D,D,D,IF
    bus.if_req = 1; bus.if_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800; bus.d_be = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("arb_req%0d", k), 32'(bus.mem_req), 1);
      chk($sformatf("arb_addr%0d", k), bus.mem_addr, (exp_d[k] != 0) ? 32'h800 : 32'h400);
      chk($sformatf("arb_starve%0d", k), 32'(dut.starve_cnt_q), 32'(exp_sc[k]));
      bus.mem_ack = 1; bus.mem_rdata = 32'h1000 + 32'(k);
      #1 chk($sformatf("arb_dv%0d", k), 32'(bus.d_valid), 32'(exp_d[k]));
      chk($sformatf("arb_iv%0d", k), 32'(bus.if_valid), (exp_d[k] != 0) ? 32'd0 : 32'd1);
      if (k == 7) begin bus.if_req = 0; bus.d_req = 0; end
      step();
      bus.mem_ack = 0;
      #1 chk($sformatf("arb_turn%0d", k), 32'(bus.mem_req), 0);
    end

    // Store
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004;
    bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b0011;
    step();
    chk("st_req", 32'(bus.mem_req), 1);
    chk("st_we", 32'(bus.mem_we), 1);
    chk("st_addr", bus.mem_addr, 32'h2004);
    chk("st_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("st_be", 32'(bus.mem_be), 32'h3);
    #1 chk("st_dv_early", 32'(bus.d_valid), 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0;
    #1 chk("st_dvalid", 32'(bus.d_valid), 1);
    chk("st_noifv", 32'(bus.if_valid), 0);
    chk("st_err", 32'(bus.bus_err), 0);
    bus.d_req = 0;
    step();
    bus.mem_ack = 0;
    #1 chk("st_req_drop", 32'(bus.mem_req), 0);

    // Timeout with no ack (TIMEOUT=8), then with ack in the 8th cycle
    for (int t = 0; t < 2; t++) begin
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; bus.d_be = 4'hF;
      bus.mem_rdata = 32'h12345678;
      for (int i = 1; i <= 8; i++) begin
        step();
        if (t == 1 && i == 8) bus.mem_ack = 1;
        #1 chk($sformatf("to%0d_req%0d", t, i), 32'(bus.mem_req), 1);
        chk($sformatf("to%0d_dv%0d", t, i), 32'(bus.d_valid), (i == 8) ? 32'd1 : 32'd0);
        chk($sformatf("to%0d_err%0d", t, i), 32'(bus.bus_err), (t == 0 && i == 8) ? 32'd1 : 32'd0);
        if (i == 8) begin
          chk($sformatf("to%0d_rdata", t), bus.d_rdata, (t == 0) ? 32'd0 : 32'h12345678);
          bus.d_req = 0;
        end
      end
      step();
      bus.mem_ack = 0;
      #1 chk($sformatf("to%0d_idle", t), 32'(bus.mem_req), 0);
      chk($sformatf("to%0d_dv_after", t), 32'(bus.d_valid), 0);
    end

    // Reset while BUSY_D, late ack afterwards, then a normal fetch
    bus.d_req = 1; bus.d_addr = 32'h4000;
    step();
    chk("rb_req", 32'(bus.mem_req), 1);
    nreset = 0; bus.d_req = 0;
    step();
    nreset = 1;
    chk("rb_req_drop", 32'(bus.mem_req), 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'hBAD0BAD0;
    bus.if_req = 1; bus.if_addr = 32'h500;
    #1 chk("rb_late_dv", 32'(bus.d_valid), 0);
    chk("rb_late_iv", 32'(bus.if_valid), 0);
    step();
    bus.mem_ack = 0;
    chk("rb_f_req", 32'(bus.mem_req), 1);
    chk("rb_f_addr", bus.mem_addr, 32'h500);
    chk("rb_f_be", 32'(bus.mem_be), 32'hF);
    bus.mem_ack = 1; bus.mem_rdata = 32'h00000013;
    #1 chk("rb_f_valid", 32'(bus.if_valid), 1);
    chk("rb_f_rdata", bus.if_rdata, 32'h00000013);
    bus.if_req = 0;
    step();
    bus.mem_ack = 0;

    // Data requester drops req and changes address mid-flight
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h6000;
    step();
    bus.d_req = 0; bus.d_addr = 32'h7777;
    step();
    chk("drop_addr", bus.mem_addr, 32'h6000);
    chk("drop_req", 32'(bus.mem_req), 1);
    #1 chk("drop_dv_early", 32'(bus.d_valid), 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE0001;
    #1 chk("drop_dvalid", 32'(bus.d_valid), 1);
    chk("drop_stall", 32'(bus.stall_d_req), 0);
    step();
    bus.mem_ack = 0;
    #1 chk("drop_idle", 32'(bus.mem_req), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
